// File: rtl/log_pkg.sv
// Shared logger definitions: state codes and default widths.
// The log address counter uses the same widths.
package log_pkg;
  localparam int LOG_ADDR_W = 15;
  localparam int LOG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOGGING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } log_state_t;
endpackage

// File: rtl/log_ctrl_if.sv
// Micro command/status and address-counter/BRAM signals of log_ctrl.
// The slave modport is the controller side.
interface log_ctrl_if #(
  parameter int ADDR_W = log_pkg::LOG_ADDR_W,
  parameter int DATA_W = log_pkg::LOG_DATA_W
);
  logic              i_cmd_start;
  logic              i_cmd_read;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic              i_mem_full;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_run_log;
  logic              o_read_log;
  logic [ADDR_W-1:0] o_addr_log_to_mem;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic [1:0]        o_state;

  modport slave (
    input  i_cmd_start, i_cmd_read, i_cmd_addr, i_mem_full, i_mem_data,
    output o_run_log, o_read_log, o_addr_log_to_mem, o_rd_data, o_rd_valid,
           o_busy, o_state
  );

  modport master (
    output i_cmd_start, i_cmd_read, i_cmd_addr, i_mem_full, i_mem_data,
    input  o_run_log, o_read_log, o_addr_log_to_mem, o_rd_data, o_rd_valid,
           o_busy, o_state
  );
endinterface

// File: rtl/cmd_sync_edge.sv
// Two-flop synchronizer for a level command, plus a one-cycle rising-edge pulse.
module cmd_sync_edge (
  input  logic clock,
  input  logic i_reset,
  input  logic d,
  output logic pulse
);
  logic sync1, sync2, prev;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;
endmodule

// File: rtl/log_ctrl.sv
// Logger command stage: turns micro start/read levels into address-counter
// controls and captures the BRAM word RD_LAT (1..4) clocks after the load.
module log_ctrl
  import log_pkg::*;
#(
  parameter int ADDR_W = LOG_ADDR_W,
  parameter int DATA_W = LOG_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic      clock,
  input  logic      i_reset,
  log_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(RD_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_LAT + 1);

  logic start_edge, read_edge;

  cmd_sync_edge u_start (.clock(clock), .i_reset(i_reset), .d(bus.i_cmd_start), .pulse(start_edge));
  cmd_sync_edge u_read  (.clock(clock), .i_reset(i_reset), .d(bus.i_cmd_read),  .pulse(read_edge));

  log_state_t        state_q, state_d;
  logic              run_q, run_d;
  logic              rd_load_q, rd_load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      rd_load_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      rd_load_q <= rd_load_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d == LOGGING) || (state_d == READING);
      cnt_q     <= cnt_d;
    end
  end

  // Edges not valid for the current state fall through untouched: dropped, never queued.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    rd_load_d = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = LOGGING;
        run_d   = 1'b1;
      end
      LOGGING: if (bus.i_mem_full) begin
        state_d = FULL;
        run_d   = 1'b0;
      end
      FULL: if (read_edge) begin
        state_d   = READING;
        rd_load_d = 1'b1;
        addr_d    = bus.i_cmd_addr;
        valid_d   = 1'b0;
        cnt_d     = '0;
      end
      READING: begin
        // One clock for the counter to load its address, then RD_LAT for the BRAM.
        if (cnt_q == CNT_MAX) begin
          data_d  = bus.i_mem_data;
          valid_d = 1'b1;
          state_d = FULL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_run_log         = run_q;
  assign bus.o_read_log        = rd_load_q;
  assign bus.o_addr_log_to_mem = addr_q;
  assign bus.o_rd_data         = data_q;
  assign bus.o_rd_valid        = valid_q;
  assign bus.o_busy            = busy_q;
  assign bus.o_state           = state_q;
endmodule

// File: doc/log_ctrl.md
Name: log_ctrl

Overview:
Command/control stage directly upstream of the log address counter in the memory logger.
- Turns slow, level-type commands from the micro (start, read, read address) into the counter's i_run_log / i_read_log / i_addr_log_to_mem controls.
- Tracks logger state and captures the BRAM read word for the micro with a fixed read latency.
- Gives the micro a clean start/full/read/valid protocol.

Parameters:
ADDR_W, 15, width of log memory address; must match the address counter.
DATA_W, 32, width of one log word read back from memory.
RD_LAT, 1, BRAM read latency in clocks from address valid to data valid (1..4).

Ports:
clock  in  1  system clock.
i_reset  in  1  asynchronous, active-low reset.
i_cmd_start  in  1  micro start-logging request, level, micro domain.
i_cmd_read  in  1  micro read request, level, micro domain; rising edge = one read.
i_cmd_addr  in  ADDR_W  micro read address; stable before i_cmd_read rises.
i_mem_full  in  1  full flag from the address counter.
i_mem_data  in  DATA_W  BRAM read data.
o_run_log  out  1  run enable to the address counter.
o_read_log  out  1  one-cycle read-load strobe to the address counter.
o_addr_log_to_mem  out  ADDR_W  captured read address to the address counter.
o_rd_data  out  DATA_W  captured read word for the micro.
o_rd_valid  out  1  o_rd_data valid; held until the next read is accepted.
o_busy  out  1  high in LOGGING and READING.
o_state  out  2  current state code, for micro status.

Behaviour:
- Reset (async, active-low):
  - state=IDLE.
  - All outputs 0, o_rd_data=0.
  - Synchronizer flops = 0.
- Synchronization:
  - i_cmd_start and i_cmd_read each pass through a 2-flop synchronizer, then a third "previous" flop.
  - start_edge = sync2 & ~prev; read_edge is formed the same way.
  - i_cmd_addr is not synchronized; it is sampled only on the read_edge cycle.
- All outputs are registered.
- State codes: IDLE=0, LOGGING=1, FULL=2, READING=3.
- IDLE:
  - start_edge -> LOGGING; o_run_log=1 from the same edge.
  - i_cmd_start high at edge k gives o_run_log high after edge k+2.
  - read_edge is ignored.
- LOGGING:
  - o_run_log held 1.
  - i_mem_full sampled 1 -> FULL; o_run_log=0 at that same edge.
  - The one extra run cycle seen by the counter is harmless, since the counter gates on its own full flag.
  - start_edge and read_edge are ignored.
- FULL:
  - read_edge -> READING.
  - At the same edge: o_read_log=1, o_addr_log_to_mem=i_cmd_addr, o_rd_valid=0, latency counter loaded.
  - start_edge is ignored. The counter's full flag clears only on reset, so a restart requires i_reset.
- READING:
  - o_read_log drops to 0 after exactly one cycle.
  - Let N be the edge that accepted the read. The counter loads its address at N+1 and data is valid RD_LAT cycles later.
  - At edge N+2+RD_LAT: o_rd_data=i_mem_data, o_rd_valid=1, state -> FULL.
  - Any read_edge or start_edge during READING is dropped, not queued.
- Simultaneous start_edge and read_edge: only the edge valid for the current state acts; the other is dropped.
- o_addr_log_to_mem holds its last captured value outside reads.
- Reset mid-LOGGING or mid-READING: immediate return to IDLE with all outputs 0. The micro must re-raise its commands (a low-to-high transition) after reset.
- Latency counter: ceil(log2(RD_LAT+2)) bits; no wrap, stops at terminal value.

Decomposition:
- Shared package log_pkg:
  - state codes IDLE/LOGGING/FULL/READING.
  - default ADDR_W=15 and DATA_W=32, shared with the address counter.
- Sub-module: cmd_sync_edge (2-flop synchronizer plus rising-edge pulse, async active-low reset). Instantiated twice, for start and read.
- FSM, latency counter and capture registers stay in log_ctrl.

Test Plan:
- Reset behaviour: hold i_reset=0 with random inputs -> all outputs 0, o_state=0. Release with i_cmd_start=1 already high -> o_run_log rises 3 edges later (the edge exists because the flops reset to 0).
- Logging run: start pulse -> o_run_log=1, o_state=1, o_busy=1. Model counter asserts i_mem_full after 32768 cycles -> o_run_log=0 at the next edge, o_state=2, o_busy=0.
- Single read (RD_LAT=1): i_cmd_addr=0x1234, raise i_cmd_read; model BRAM returns 0xCAFE0000|addr.
  - Exactly one o_read_log pulse with o_addr_log_to_mem=0x1234.
  - Accepting edge N: o_rd_valid=1 with o_rd_data=0xCAFE1234 at edge N+3; o_state back to 2.
- Back-to-back reads: read toggled every 2 cycles -> edges during READING are dropped, no second o_read_log. A read after return to FULL gives valid data for the new address. Repeat for RD_LAT=3: valid at N+5.
- Ignored commands:
  - read_edge in IDLE and LOGGING -> no o_read_log.
  - start_edge in FULL -> o_run_log stays 0.
  - Start and read edges in the same cycle in IDLE -> LOGGING only.
- Reset mid-read: assert i_reset at N+1 of a read -> outputs 0 immediately, o_rd_valid never rises, state IDLE after release.
